// File: rtl/b_pkg.sv
// Shared types and constants for the branch commit queue.
package b_pkg;

  localparam int BRQ_DEPTH = 8;

  // One queue slot: allocation-time prediction plus execution-time outcome.
  typedef struct packed {
    logic        vld;
    logic        done;
    logic [31:0] pc;
    logic        p_taken;
    logic [31:0] p_target;
    logic        a_taken;
    logic [31:0] a_target;
  } brq_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } brq_state_t;

endpackage

// File: rtl/b_mispredict_chk.sv
// Compares a branch's predicted outcome with its actual outcome and
// produces the correct next fetch PC.
module b_mispredict_chk (
  input  logic        p_taken,
  input  logic [31:0] p_target,
  input  logic        a_taken,
  input  logic [31:0] a_target,
  input  logic [31:0] pc,
  output logic        dm,
  output logic        tm,
  output logic [31:0] next_pc
);

  // Direction miss, target miss (only meaningful when actually taken), and
  // the architecturally correct successor PC (wraps at 2^32).
  always_comb begin
    dm      = (p_taken != a_taken);
    tm      = a_taken && (p_target != a_target);
    next_pc = a_taken ? a_target : (pc + 32'd4);
  end

endmodule

// File: rtl/b_commit_queue.sv
// In-order branch commit queue: allocates in program order, resolves out of
// order by tag, retires one entry per cycle into the predictor and flushes
// all younger entries on a mispredict.
module b_commit_queue
  import b_pkg::*;
#(
  parameter int DEPTH = BRQ_DEPTH,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  input  logic [31:0]      alloc_pc,
  input  logic             alloc_taken,
  input  logic [31:0]      alloc_target,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             res_valid,
  input  logic [TAG_W-1:0] res_tag,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  input  logic             retire_en,
  output logic             branch_commit,
  output logic [31:0]      pc_head,
  output logic             direct_resolved,
  output logic [31:0]      pc_resolved,
  output logic             direct_mispredict,
  output logic             flush,
  output logic [31:0]      flush_pc,
  output logic [TAG_W:0]   count
);

  localparam logic [TAG_W:0] DEPTH_C = (TAG_W + 1)'(DEPTH);

  brq_entry_t       entry_q [DEPTH];
  brq_entry_t       entry_d [DEPTH];
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  brq_state_t       state_q, state_d;

  logic             branch_commit_q, branch_commit_d;
  logic [31:0]      pc_head_q, pc_head_d;
  logic             direct_resolved_q, direct_resolved_d;
  logic [31:0]      pc_resolved_q, pc_resolved_d;
  logic             direct_mispredict_q, direct_mispredict_d;
  logic             flush_q, flush_d;
  logic [31:0]      flush_pc_q, flush_pc_d;

  brq_entry_t       head_ent;
  logic             retire;
  logic             alloc_fire;
  logic             head_dm;
  logic             head_tm;
  logic             head_mispredict;
  logic [31:0]      head_next_pc;

  // Handshake outputs come from registered state only.
  always_comb begin
    alloc_ready = (state_q == RUN) && (count_q < DEPTH_C);
    alloc_tag   = tail_q;
    count       = count_q;
  end

  // Head-entry view and the retire / allocate qualifiers.
  always_comb begin
    head_ent        = entry_q[head_q];
    retire          = (state_q == RUN) && head_ent.vld && head_ent.done && retire_en;
    alloc_fire      = alloc_valid && alloc_ready;
    head_mispredict = head_dm || head_tm;
  end

  b_mispredict_chk u_chk (
    .p_taken  (head_ent.p_taken),
    .p_target (head_ent.p_target),
    .a_taken  (head_ent.a_taken),
    .a_target (head_ent.a_target),
    .pc       (head_ent.pc),
    .dm       (head_dm),
    .tm       (head_tm),
    .next_pc  (head_next_pc)
  );

  // Next-state logic: RUN handles alloc/resolve/retire; FLUSH is a single
  // dead cycle that ignores the front end while the pipeline redirects.
  always_comb begin
    entry_d             = entry_q;
    head_d              = head_q;
    tail_d              = tail_q;
    count_d             = count_q;
    state_d             = state_q;
    branch_commit_d     = 1'b0;
    direct_mispredict_d = 1'b0;
    flush_d             = 1'b0;
    pc_head_d           = pc_head_q;
    direct_resolved_d   = direct_resolved_q;
    pc_resolved_d       = pc_resolved_q;
    flush_pc_d          = flush_pc_q;

    case (state_q)
      RUN: begin
        if (retire) begin
          entry_d[head_q].vld = 1'b0;
          head_d              = head_q + 1'b1;
          branch_commit_d     = 1'b1;
          pc_head_d           = head_ent.pc;
          direct_resolved_d   = head_ent.a_taken;
          pc_resolved_d       = head_next_pc;
          flush_pc_d          = head_next_pc;
          direct_mispredict_d = head_dm;
          flush_d             = head_mispredict;
        end

        if (retire && head_mispredict) begin
          // Everything younger than the mispredicted branch is wrong-path.
          for (int i = 0; i < DEPTH; i++) begin
            entry_d[i].vld = 1'b0;
          end
          tail_d  = head_q + 1'b1;
          count_d = '0;
          state_d = FLUSH;
        end else begin
          // A resolution only lands on a live, not-yet-resolved entry.
          if (res_valid && entry_q[res_tag].vld && !entry_q[res_tag].done) begin
            entry_d[res_tag].done     = 1'b1;
            entry_d[res_tag].a_taken  = res_taken;
            entry_d[res_tag].a_target = res_target;
          end
          if (alloc_fire) begin
            entry_d[tail_q] = '{vld: 1'b1, done: 1'b0, pc: alloc_pc,
                                p_taken: alloc_taken, p_target: alloc_target,
                                a_taken: 1'b0, a_target: 32'd0};
            tail_d = tail_q + 1'b1;
          end
          count_d = count_q + (TAG_W + 1)'(alloc_fire) - (TAG_W + 1)'(retire);
        end
      end

      FLUSH: begin
        state_d = RUN;
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      head_q              <= '0;
      tail_q              <= '0;
      count_q             <= '0;
      state_q             <= RUN;
      branch_commit_q     <= 1'b0;
      pc_head_q           <= '0;
      direct_resolved_q   <= 1'b0;
      pc_resolved_q       <= '0;
      direct_mispredict_q <= 1'b0;
      flush_q             <= 1'b0;
      flush_pc_q          <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
      head_q              <= head_d;
      tail_q              <= tail_d;
      count_q             <= count_d;
      state_q             <= state_d;
      branch_commit_q     <= branch_commit_d;
      pc_head_q           <= pc_head_d;
      direct_resolved_q   <= direct_resolved_d;
      pc_resolved_q       <= pc_resolved_d;
      direct_mispredict_q <= direct_mispredict_d;
      flush_q             <= flush_d;
      flush_pc_q          <= flush_pc_d;
    end
  end

  // Registered commit/flush outputs.
  always_comb begin
    branch_commit     = branch_commit_q;
    pc_head           = pc_head_q;
    direct_resolved   = direct_resolved_q;
    pc_resolved       = pc_resolved_q;
    direct_mispredict = direct_mispredict_q;
    flush             = flush_q;
    flush_pc          = flush_pc_q;
  end

endmodule

// File: tb/tb_b_commit_queue.sv
// Self-checking bench for b_commit_queue: directed scenarios plus random
// traffic, all checked against a queue-based reference model.
module tb_b_commit_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [31:0] alloc_pc;
  logic        alloc_taken;
  logic [31:0] alloc_target;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        res_valid;
  logic [2:0]  res_tag;
  logic        res_taken;
  logic [31:0] res_target;
  logic        retire_en;
  logic        branch_commit;
  logic [31:0] pc_head;
  logic        direct_resolved;
  logic [31:0] pc_resolved;
  logic        direct_mispredict;
  logic        flush;
  logic [31:0] flush_pc;
  logic [3:0]  count;

  b_commit_queue dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_taken(alloc_taken),
    .alloc_target(alloc_target), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken),
    .res_target(res_target), .retire_en(retire_en),
    .branch_commit(branch_commit), .pc_head(pc_head),
    .direct_resolved(direct_resolved), .pc_resolved(pc_resolved),
    .direct_mispredict(direct_mispredict), .flush(flush), .flush_pc(flush_pc),
    .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: program-ordered list of in-flight branches.
  typedef struct {
    logic [2:0]  tag;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptg;
    logic        done;
    logic        at;
    logic [31:0] atg;
  } ment_t;

  ment_t       mq[$];
  int          m_tail;
  bit          m_flush;
  logic        e_commit, e_dm, e_flush, e_dr;
  logic [31:0] e_pc_head, e_pres, e_fpc;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_tail = 0; m_flush = 0;
    e_commit = 0; e_dm = 0; e_flush = 0; e_dr = 0;
    e_pc_head = 0; e_pres = 0; e_fpc = 0;
  endtask

  task automatic check_all();
    chk("alloc_ready", 32'(alloc_ready), 32'(!m_flush && mq.size() < DEPTH));
    chk("alloc_tag", 32'(alloc_tag), 32'(m_tail));
    chk("count", 32'(count), 32'(mq.size()));
    chk("branch_commit", 32'(branch_commit), 32'(e_commit));
    chk("direct_mispredict", 32'(direct_mispredict), 32'(e_dm));
    chk("flush", 32'(flush), 32'(e_flush));
    chk("pc_head", pc_head, e_pc_head);
    chk("direct_resolved", 32'(direct_resolved), 32'(e_dr));
    chk("pc_resolved", pc_resolved, e_pres);
    chk("flush_pc", flush_pc, e_fpc);
  endtask

  // One clock: decide from pre-edge model state, advance, compare.
  task automatic cycle();
    bit    do_ret, do_alloc, do_res, dm, tm;
    ment_t h;
    do_ret   = !m_flush && mq.size() > 0 && mq[0].done && retire_en;
    do_alloc = alloc_valid && !m_flush && mq.size() < DEPTH;
    do_res   = res_valid && !m_flush;
    @(posedge clk); #1;
    e_commit = do_ret; e_dm = 0; e_flush = 0;
    if (do_ret) begin
      h = mq.pop_front();
      dm = (h.pt != h.at);
      tm = h.at && (h.ptg != h.atg);
      e_pc_head = h.pc; e_dr = h.at;
      e_pres = h.at ? h.atg : h.pc + 32'd4;
      e_fpc = e_pres; e_dm = dm; e_flush = dm || tm;
      $display("commit tag=%0d pc=0x%08h taken=%0d next=0x%08h dm=%0d flush=%0d",
               h.tag, h.pc, h.at, e_pres, dm, dm || tm);
    end
    m_flush = e_flush;
    if (e_flush) begin
      mq.delete();
      m_tail = (int'(h.tag) + 1) % DEPTH;
    end else begin
      if (do_res)
        foreach (mq[i])
          if (mq[i].tag == res_tag && !mq[i].done) begin
            mq[i].done = 1; mq[i].at = res_taken; mq[i].atg = res_target;
          end
      if (do_alloc) begin
        mq.push_back('{tag: 3'(m_tail), pc: alloc_pc, pt: alloc_taken, ptg: alloc_target,
                       done: 1'b0, at: 1'b0, atg: 32'd0});
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
    check_all();
  endtask

  task automatic drive(input logic av, input logic [31:0] apc, input logic at,
                       input logic [31:0] atg, input logic rv, input logic [2:0] rtag,
                       input logic rt, input logic [31:0] rtg, input logic re);
    alloc_valid = av; alloc_pc = apc; alloc_taken = at; alloc_target = atg;
    res_valid = rv; res_tag = rtag; res_taken = rt; res_target = rtg; retire_en = re;
    cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    rst = 1'b0;
    check_all();
  endtask

  initial begin
    rst = 0; alloc_valid = 0; alloc_pc = 0; alloc_taken = 0; alloc_target = 0;
    res_valid = 0; res_tag = 0; res_taken = 0; res_target = 0; retire_en = 0;
    model_reset();
    #2;
    do_reset();

    // Fill all eight slots with no retires; a ninth allocation is refused.
    for (int i = 0; i < DEPTH; i++)
      drive(1, 32'h100 + 32'(4 * i), 0, 32'h0, 0, 0, 0, 0, 0);
    chk("full_count", 32'(count), 32'd8);
    chk("full_ready", 32'(alloc_ready), 32'd0);
    chk("full_tag_wrap", 32'(alloc_tag), 32'd0);
    drive(1, 32'h999, 0, 32'h0, 0, 0, 0, 0, 0);

    // In-order retire after out-of-order resolution.
    do_reset();
    for (int i = 0; i < 3; i++)
      drive(1, 32'h100 + 32'(4 * i), 0, 32'h0, 0, 0, 0, 0, 1);
    for (int i = 2; i >= 0; i--)
      drive(0, 0, 0, 0, 1, 3'(i), 0, 32'h0, 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Direction mispredict at 0x200, allocation during FLUSH is dropped.
    drive(1, 32'h200, 0, 32'h0, 0, 0, 0, 0, 0);
    drive(1, 32'h204, 0, 32'h0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 3'(m_tail - 2), 1, 32'h400, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("dm_flush", 32'(flush), 32'd1);
    chk("dm_flush_pc", flush_pc, 32'h400);
    chk("dm_count", 32'(count), 32'd0);
    drive(1, 32'h208, 0, 32'h0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Target-only mispredict.
    drive(1, 32'h280, 1, 32'h300, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 3'(m_tail - 1), 1, 32'h340, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("tm_dm", 32'(direct_mispredict), 32'd0);
    chk("tm_flush_pc", flush_pc, 32'h340);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Re-resolving a done tag and an invalid tag; retire held off 3 cycles.
    // Also exercises pc+4 wrap-around at the top of the address space.
    drive(1, 32'hFFFF_FFFC, 0, 32'h0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 3'(m_tail - 1), 0, 32'h0, 0);
    drive(0, 0, 0, 0, 1, 3'(m_tail - 1), 1, 32'h777, 0);
    drive(0, 0, 0, 0, 1, 3'(m_tail + 3), 1, 32'h888, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("held_no_commit", 32'(branch_commit), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("wrap_pc_resolved", pc_resolved, 32'h0);

    // Reset with five entries in flight and a commit pulse showing.
    for (int i = 0; i < 5; i++)
      drive(1, 32'h500 + 32'(4 * i), 0, 32'h0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 3'(m_tail - 5), 0, 32'h0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("pre_reset_commit", 32'(branch_commit), 32'd1);
    do_reset();
    chk("post_reset_count", 32'(count), 32'd0);
    chk("post_reset_tag", 32'(alloc_tag), 32'd0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      logic        rv, rt;
      logic [2:0]  rtag;
      logic [31:0] rtg;
      int          idx;
      rv = ($urandom_range(3) != 0);
      rtag = 3'($urandom_range(7)); rt = 1'($urandom); rtg = $urandom & ~32'h3;
      if (mq.size() > 0 && $urandom_range(4) != 0) begin
        idx = $urandom_range(mq.size() - 1);
        rtag = mq[idx].tag;
        rt = ($urandom_range(9) == 0) ? ~mq[idx].pt : mq[idx].pt;
        rtg = ($urandom_range(9) == 0) ? rtg : mq[idx].ptg;
      end
      drive(1'($urandom_range(2) != 0), $urandom & ~32'h3, 1'($urandom),
            $urandom & ~32'h3, rv, rtag, rt, rtg, 1'($urandom_range(3) != 0));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/b_commit_queue.md
# b_commit_queue

In-order branch commit queue that sequences updates into the branch predictor (`b_predictor`). Each predicted branch is allocated in program order when it issues. Execution resolves entries out of order by tag. The queue retires them strictly in order, one per cycle, and drives the predictor's commit, mispredict and resolved-target inputs. On a mispredict it raises a pipeline flush and discards all younger (wrong-path) entries.

## Interface
Parameters:
- `DEPTH`, 8: number of entries; must be a power of two, ≥2.
- `TAG_W`, 3: equals log2(`DEPTH`).

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `alloc_valid` in 1: allocate a new branch this cycle.
- `alloc_pc` in 32: PC of the branch.
- `alloc_taken` in 1: predicted direction.
- `alloc_target` in 32: predicted target (BTB output).
- `alloc_ready` out 1: queue can accept an allocation.
- `alloc_tag` out TAG_W: tag assigned to the current allocation (equals the tail pointer).
- `res_valid` in 1: a branch resolution is presented.
- `res_tag` in TAG_W: tag of the resolved entry.
- `res_taken` in 1: actual direction.
- `res_target` in 32: actual next PC when taken.
- `retire_en` in 1: ROB permits the head branch to commit.
- `branch_commit` out 1: one-cycle commit pulse to the predictor.
- `pc_head` out 32: PC of the committing branch.
- `direct_resolved` out 1: actual direction of the committing branch.
- `pc_resolved` out 32: actual target of the committing branch.
- `direct_mispredict` out 1: direction of the committing branch was mispredicted.
- `flush` out 1: one-cycle pipeline flush pulse.
- `flush_pc` out 32: correct fetch PC when `flush` is asserted.
- `count` out TAG_W+1: number of occupied entries.

## Operation
- Storage: circular buffer with head and tail pointers. Each entry holds `vld`, `done`, `pc`, `p_taken`, `p_target`, `a_taken`, `a_target`.
- FSM states: RUN and FLUSH.
  - RUN → FLUSH when an entry retires with a mispredict.
  - FLUSH → RUN unconditionally after one cycle.
  - In FLUSH, `alloc_ready`=0, and both allocations and resolutions are ignored.
- Allocate (RUN, `alloc_valid` && `alloc_ready`):
  - Write the entry at tail with `vld`=1 and `done`=0.
  - Tail advances by 1, wrapping modulo `DEPTH`.
- `alloc_ready` = (state==RUN) && (`count` < `DEPTH`). It does not anticipate a same-cycle retire.
- Resolve (RUN, `res_valid`):
  - If entry[`res_tag`] has `vld`=1 and `done`=0, write `a_taken` and `a_target` and set `done`=1.
  - Otherwise the resolution is ignored; no error is raised.
- Retire condition: RUN && entry[head].`vld` && entry[head].`done` && `retire_en`. When it holds:
  - Clear the entry's `vld` and advance head.
  - Direction mispredict `dm` = `p_taken` != `a_taken`.
  - Target mispredict `tm` = `a_taken` && (`p_target` != `a_target`).
- Mispredict (`dm` || `tm`):
  - On the same edge, every entry is invalidated.
  - head = tail = head+1, and `count` becomes 0.
  - A same-cycle allocation or resolution is dropped.
- Retired-entry outputs on the next cycle: `pc_resolved` = `a_taken` ? `a_target` : `pc`+4, using 32-bit wrap-around arithmetic. `flush_pc` takes the same value.
- `count` updates as +1 on allocate, −1 on retire, unchanged when both occur, and 0 on a flush.

## Timing
- Reset values: all entries invalid, head = tail = 0, state RUN, and `alloc_ready`=1, `alloc_tag`=0, `count`=0.
- All commit/flush outputs are 0 at reset: `branch_commit`, `direct_mispredict`, `flush`, `pc_head`, `direct_resolved`, `pc_resolved`, `flush_pc`.
- `alloc_ready`, `alloc_tag` and `count` are derived combinationally from registered state only; they never depend on same-cycle inputs.
- Commit outputs are registered. A retire decided at edge N gives `branch_commit` high for exactly the cycle after N, with `pc_head`, `direct_resolved` and `pc_resolved` valid alongside it.
- `direct_mispredict` = `dm`, qualified by `branch_commit`.
- `flush` = `dm`||`tm`, qualified by `branch_commit`. It is high during the single FLUSH-state cycle.
- Data outputs hold their last value while `branch_commit`=0.
- A resolution takes effect at the edge. An entry resolved at edge N can retire at edge N+1 at the earliest.
- Throughput: one allocation, one resolution and one retire per cycle.
- Reset asserted mid-operation immediately clears all state and drops any pending pulse.

## Structure
- Shared package `b_pkg` holds:
  - typedef `brq_entry_t` (packed struct of the entry fields);
  - localparam `BRQ_DEPTH`=8;
  - the FSM enum `brq_state_t` {RUN, FLUSH}.
- Sub-module `b_mispredict_chk`: combinational; inputs `p_taken`, `p_target`, `a_taken`, `a_target`, `pc`; outputs `dm`, `tm`, next PC.
- Everything else lives in `b_commit_queue`.

## Test plan
- Reset, then allocate 8 branches with no retires → `count`=8, `alloc_ready`=0, and `alloc_tag` wraps back to 0.
- Allocate tags 0, 1, 2; resolve 2, 1, 0 (all correctly predicted); hold `retire_en`=1 → three `branch_commit` pulses in order, `pc_head` = 0x100, 0x104, 0x108, `flush` never asserted.
- Head at `pc`=0x200 predicted not-taken, resolved taken with `a_target`=0x400 → `branch_commit`=1, `direct_mispredict`=1, `flush`=1, `flush_pc`=0x400, `count`=0; an allocation during the FLUSH cycle is ignored.
- Predicted taken to 0x300, resolved taken to 0x340 → `direct_mispredict`=0, `flush`=1, `flush_pc`=0x340, `direct_resolved`=1.
- Resolve a tag that is already done or invalid → no state change. Resolve head with `retire_en`=0 for 3 cycles → no commit until `retire_en` rises.
- Assert reset while the queue holds 5 entries and a commit pulse is pending → next cycle all outputs are 0, `count`=0, `alloc_tag`=0.
